// File: rtl/wb_stage_param.sv
// RV32I/RV64I writeback stage: MEM/WB register, load align/extend, result select.
// Define WB_RETIRE_CNT_EN to add the 64-bit retire_cnt_o counter.
module wb_stage_param #(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] read_data_m,
  input  logic [XLEN-1:0] pc_plus4_m,
  input  logic [1:0]      result_src_m,
  input  logic            reg_write_m,
  input  logic [4:0]      rd_m,
  input  logic [2:0]      funct3_m,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]     retire_cnt_o,
`endif
  output logic [XLEN-1:0] result_w,
  output logic [4:0]      rd_w,
  output logic            reg_write_w,
  output logic            valid_w,
  output logic            misalign_w
);

  logic            valid_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic [1:0]      src_q;
  logic            regw_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      src_q   <= '0;
      regw_q  <= 1'b0;
      rd_q    <= '0;
      f3_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= valid_m;
      alu_q   <= alu_result_m;
      rdata_q <= read_data_m;
      pc4_q   <= pc_plus4_m;
      src_q   <= result_src_m;
      regw_q  <= reg_write_m;
      rd_q    <= rd_m;
      f3_q    <= funct3_m;
    end
  end

  logic [OFFW-1:0] off;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld;
  logic            mis;

  assign off  = alu_q[OFFW-1:0];
  assign lane = rdata_q >> {off, 3'b000};

  // 64-bit-only codes fall through to zero on RV32
  always_comb begin
    ld = '0;
    case (f3_q)
      3'b000:  ld = XLEN'($signed(lane[7:0]));
      3'b100:  ld = XLEN'(lane[7:0]);
      3'b001:  ld = XLEN'($signed(lane[15:0]));
      3'b101:  ld = XLEN'(lane[15:0]);
      3'b010:  ld = XLEN'($signed(lane[31:0]));
      3'b110:  if (XLEN == 64) ld = XLEN'(lane[31:0]);
      3'b011:  if (XLEN == 64) ld = lane;
      default: ld = '0;
    endcase
  end

  always_comb begin
    mis = 1'b0;
    case (f3_q[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = (XLEN == 64) && (|off);
      default: mis = 1'b0;
    endcase
  end

  assign misalign_w = valid_q && (src_q == 2'b01) && mis;

  always_comb begin
    result_w = '0;
    case (src_q)
      2'b00:   result_w = alu_q;
      2'b01:   result_w = ld;
      2'b10:   result_w = pc4_q;
      default: result_w = '0;
    endcase
  end

  assign valid_w     = valid_q;
  assign rd_w        = rd_q;
  assign reg_write_w = valid_q && regw_q && (rd_q != 5'd0) && !misalign_w;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // An instruction retires when it leaves WB cleanly
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !misalign_w && !stall_i) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retire_cnt_o = cnt_q;
`endif

endmodule
